// File: rtl/score_display_scan.sv
// score_display_scan: hit count (BCD via double-dabble) and level on an 8-digit multiplexed seven-segment display
// Ports: Clk system clock; Rst sync active-high reset; Hits 8-bit hit count; Level 4-bit zero-based level;
//        Seg {g,f,e,d,c,b,a} active-low; An digit enables active-low (bit 0 = rightmost); Busy conversion in progress
module score_display_scan #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic [7:0] Hits,
   input  logic [3:0] Level,
   output logic [6:0] Seg,
   output logic [7:0] An,
   output logic       Busy
);
   localparam int CW = $clog2(REFRESH_DIV);
   typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;
   state_t state;
   logic [7:0] snap_hits;
   logic [3:0] snap_level;
   logic [19:0] sh, adj;
   logic [2:0] bit_cnt;
   logic [3:0] hund, tens, ones, lvl_tens, lvl_ones;
   logic [4:0] lvl_val;
   logic [CW-1:0] ref_cnt;
   logic [2:0] idx;
   logic [3:0] code;
   logic lit, wrap;
   function automatic logic [3:0] dab(input logic [3:0] n);
      return n >= 4'd5 ? n + 4'd3 : n;
   endfunction
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction
   // adjust every BCD nibble before the shift; binary part passes through untouched
   assign adj = {dab(sh[19:16]), dab(sh[15:12]), dab(sh[11:8]), sh[7:0]};
   assign lvl_val = {1'b0, snap_level} + 5'd1;
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         snap_hits <= '0;
         snap_level <= '0;
         sh <= '0;
         bit_cnt <= '0;
         hund <= '0;
         tens <= '0;
         ones <= '0;
         lvl_tens <= '0;
         lvl_ones <= 4'd1;
         Busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if ({Level, Hits} != {snap_level, snap_hits}) begin
               snap_hits <= Hits;
               snap_level <= Level;
               sh <= {12'b0, Hits};
               bit_cnt <= '0;
               state <= CONV;
               Busy <= 1'b1;
            end
            CONV: begin
               sh <= adj << 1;
               bit_cnt <= bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state <= LATCH;
            end
            LATCH: begin
               hund <= sh[19:16];
               tens <= sh[15:12];
               ones <= sh[11:8];
               lvl_tens <= {3'b0, lvl_val >= 5'd10};
               // level 16 wraps to 0 in the low nibble, so 0 - 10 still yields 6
               lvl_ones <= lvl_val >= 5'd10 ? lvl_val[3:0] - 4'd10 : lvl_val[3:0];
               state <= IDLE;
               Busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign wrap = ref_cnt == CW'(REFRESH_DIV - 1);
   assign code = idx == 3'd0 ? ones : idx == 3'd1 ? tens : idx == 3'd2 ? hund : idx == 3'd4 ? lvl_ones : lvl_tens;
   // leading-zero blanking; digits 0 and 4 always lit, 3/6/7 never
   assign lit = idx == 3'd0 || idx == 3'd4 || (idx == 3'd1 && (hund != 4'd0 || tens != 4'd0)) ||
                (idx == 3'd2 && hund != 4'd0) || (idx == 3'd5 && lvl_tens != 4'd0);
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ref_cnt <= '0;
         idx <= '0;
         Seg <= 7'h7F;
         An <= 8'hFF;
      end else begin
         ref_cnt <= wrap ? '0 : ref_cnt + CW'(1);
         if (wrap) idx <= idx + 3'd1;
         Seg <= lit ? seg7(code) : 7'h7F;
         An <= lit ? ~(8'd1 << idx) : 8'hFF;
      end
   end
endmodule

// File: tb/tb_score_display_scan.sv
// tb_score_display_scan: directed tests of conversion timing, digit map, blanking, reset and scan
module tb_score_display_scan;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   logic [7:0] Hits = '0;
   logic [3:0] Level = '0;
   logic [6:0] Seg;
   logic [7:0] An;
   logic Busy;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S4 = 7'b0011001,
                          S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000, BL = 7'h7F;
   logic [6:0] obs_seg[8];
   logic [7:0] obs_an[8];
   logic [6:0] es[8];
   logic [7:0] ea[8];
   score_display_scan #(.REFRESH_DIV(4)) dut (
      .Clk(Clk), .Rst(Rst), .Hits(Hits), .Level(Level), .Seg(Seg), .An(An), .Busy(Busy)
   );
   always #5 Clk = ~Clk;
   // bench-side scan position: edges since reset release; slot = ((cyc-1)/4) mod 8
   always @(posedge Clk) cyc <= Rst ? 0 : cyc + 1;
   task automatic capture_frame();
      for (int i = 0; i < 32; i++) begin
         @(negedge Clk);
         obs_seg[((cyc - 1) >> 2) & 7] = Seg;
         obs_an[((cyc - 1) >> 2) & 7] = An;
      end
   endtask
   task automatic wait_idle();
      int n = 0;
      @(negedge Clk);
      while (Busy && n < 30) begin
         @(negedge Clk);
         n++;
      end
      total++;
      if (Busy !== 1'b0) begin
         bad++;
         $display("FAIL wait_idle: busy=%b required 0", Busy);
      end
   endtask
   task automatic test_reset();
      Rst = 1'b1;
      repeat (3) @(negedge Clk);
      total++;
      if (An !== 8'hFF) begin bad++; $display("FAIL reset_an: got %h required ff", An); end
      total++;
      if (Seg !== 7'h7F) begin bad++; $display("FAIL reset_seg: got %b required 1111111", Seg); end
      total++;
      if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", Busy); end
      Rst = 1'b0;
      capture_frame();
      es = '{S0, BL, BL, BL, S1, BL, BL, BL};
      ea = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_seg[i] !== es[i] || obs_an[i] !== ea[i]) begin
            bad++;
            $display("FAIL reset_frame digit %0d: seg=%b an=%h required seg=%b an=%h", i, obs_seg[i], obs_an[i], es[i], ea[i]);
         end
      end
      total++;
      if (Busy !== 1'b0) begin bad++; $display("FAIL reset_no_conv: busy=%b required 0", Busy); end
   endtask
   task automatic test_max();
      Hits = 8'd255;
      Level = 4'd15;
      for (int j = 0; j < 10; j++) begin
         @(negedge Clk);
         total++;
         if (Busy !== (j < 9)) begin bad++; $display("FAIL max_busy k+%0d: got %b required %b", j, Busy, j < 9); end
      end
      capture_frame();
      es = '{S5, S5, S2, BL, S6, S1, BL, BL};
      ea = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_seg[i] !== es[i] || obs_an[i] !== ea[i]) begin
            bad++;
            $display("FAIL max_frame digit %0d: seg=%b an=%h required seg=%b an=%h", i, obs_seg[i], obs_an[i], es[i], ea[i]);
         end
      end
   endtask
   task automatic test_small();
      Hits = 8'd7;
      Level = 4'd8;
      wait_idle();
      capture_frame();
      es = '{S7, BL, BL, BL, S9, BL, BL, BL};
      ea = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_seg[i] !== es[i] || obs_an[i] !== ea[i]) begin
            bad++;
            $display("FAIL small_frame digit %0d: seg=%b an=%h required seg=%b an=%h", i, obs_seg[i], obs_an[i], es[i], ea[i]);
         end
      end
   endtask
   task automatic test_boundary();
      Hits = 8'd10;
      Level = 4'd9;
      wait_idle();
      capture_frame();
      es = '{S0, S1, BL, BL, S0, S1, BL, BL};
      ea = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hEF, 8'hDF, 8'hFF, 8'hFF};
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_seg[i] !== es[i] || obs_an[i] !== ea[i]) begin
            bad++;
            $display("FAIL boundary_frame digit %0d: seg=%b an=%h required seg=%b an=%h", i, obs_seg[i], obs_an[i], es[i], ea[i]);
         end
      end
   endtask
   task automatic test_back_to_back();
      logic [6:0] s100[8] = '{S0, S0, S1, BL, S1, BL, BL, BL};
      logic [7:0] a100[8] = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
      logic [6:0] s42[8] = '{S2, S4, BL, BL, S1, BL, BL, BL};
      logic [7:0] a42[8] = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
      logic eb;
      int s;
      Hits = 8'd100;
      Level = 4'd0;
      for (int j = 0; j < 30; j++) begin
         @(negedge Clk);
         s = ((cyc - 1) >> 2) & 7;
         eb = (j <= 8) || (j >= 10 && j <= 18);
         total++;
         if (Busy !== eb) begin bad++; $display("FAIL b2b_busy k+%0d: got %b required %b", j, Busy, eb); end
         if (j >= 10 && j < 20) begin
            total++;
            if (Seg !== s100[s] || An !== a100[s]) begin
               bad++;
               $display("FAIL b2b_show100 k+%0d slot %0d: seg=%b an=%h required seg=%b an=%h", j, s, Seg, An, s100[s], a100[s]);
            end
         end
         if (j >= 20) begin
            total++;
            if (Seg !== s42[s] || An !== a42[s]) begin
               bad++;
               $display("FAIL b2b_show42 k+%0d slot %0d: seg=%b an=%h required seg=%b an=%h", j, s, Seg, An, s42[s], a42[s]);
            end
         end
         if (j == 2) Hits = 8'd42;
      end
   endtask
   task automatic test_reset_mid();
      logic [6:0] s0[8] = '{S0, BL, BL, BL, S1, BL, BL, BL};
      logic [7:0] a0[8] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
      int s;
      Hits = 8'd200;
      Level = 4'd0;
      repeat (4) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      total++;
      if (Busy !== 1'b0 || An !== 8'hFF || Seg !== 7'h7F) begin
         bad++;
         $display("FAIL midrst_outputs: busy=%b an=%h seg=%b required busy=0 an=ff seg=1111111", Busy, An, Seg);
      end
      Rst = 1'b0;
      for (int j = 0; j < 10; j++) begin
         @(negedge Clk);
         s = ((cyc - 1) >> 2) & 7;
         total++;
         if (Busy !== (j < 9)) begin bad++; $display("FAIL midrst_busy r+%0d: got %b required %b", j, Busy, j < 9); end
         total++;
         if (Seg !== s0[s] || An !== a0[s]) begin
            bad++;
            $display("FAIL midrst_reverted r+%0d slot %0d: seg=%b an=%h required seg=%b an=%h", j, s, Seg, An, s0[s], a0[s]);
         end
      end
      capture_frame();
      es = '{S0, S0, S2, BL, S1, BL, BL, BL};
      ea = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 8; i++) begin
         total++;
         if (obs_seg[i] !== es[i] || obs_an[i] !== ea[i]) begin
            bad++;
            $display("FAIL midrst_frame digit %0d: seg=%b an=%h required seg=%b an=%h", i, obs_seg[i], obs_an[i], es[i], ea[i]);
         end
      end
   endtask
   task automatic test_scan_wrap();
      logic [6:0] s200[8] = '{S0, S0, S2, BL, S1, BL, BL, BL};
      logic [7:0] a200[8] = '{8'hFE, 8'hFD, 8'hFB, 8'hFF, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
      int s;
      int fe = 0;
      for (int j = 0; j < 64; j++) begin
         @(negedge Clk);
         s = ((cyc - 1) >> 2) & 7;
         if (An === 8'hFE) fe++;
         total++;
         if (Seg !== s200[s] || An !== a200[s]) begin
            bad++;
            $display("FAIL wrap_cycle %0d slot %0d: seg=%b an=%h required seg=%b an=%h", j, s, Seg, An, s200[s], a200[s]);
         end
      end
      total++;
      if (fe != 8) begin bad++; $display("FAIL wrap_period: digit0 cycles=%0d required 8 in two frames", fe); end
   endtask
   initial begin
      test_reset();
      test_max();
      test_small();
      test_boundary();
      test_back_to_back();
      test_reset_mid();
      test_scan_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/score_display_scan.md
# score_display_scan

Downstream display stage for the Pong top level: consumes the DataPath's hit count (8-bit binary) and level (4-bit, zero-based) and drives the board's 8-digit multiplexed seven-segment display. Converts the hit count to BCD with a sequential double-dabble engine, latches converted digits into display registers only on completion (glitch-free), and time-multiplexes digits with a parameterised refresh divider.

## Interface
- REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz/digit at 100 MHz); legal ≥ 2
- Clk  in  1  system clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- Hits  in  8  hit count, binary 0–255
- Level  in  4  zero-based level; displayed value is Level+1 (1–16), computed internally at 5 bits
- Seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- An  out  8  digit enables, active-low, bit i = digit i (0 = rightmost), registered
- Busy  out  1  high while a conversion is in progress (states CONV, LATCH)

## Operation
- Conversion FSM: IDLE, CONV, LATCH.
  - IDLE: if {Level,Hits} ≠ snapshot: load snapshot, load shift register {12'b0, Hits}, bit count ← 0, go CONV. Otherwise stay.
  - CONV: each cycle, add 3 to any BCD nibble ≥ 5, then shift left 1; after the 8th shift go LATCH.
  - LATCH: hits BCD (hundreds, tens, ones) → display regs; level display = Level_snapshot+1 split into tens (0/1) and ones (value ≥ 10 → value−10); go IDLE.
- Input changes during CONV/LATCH are ignored; the next IDLE cycle detects the mismatch and starts a fresh conversion. No conversion is aborted.
- Reset values: state IDLE, snapshot = {Level 0, Hits 0}, display regs = hits 000, level 01, bit count 0, Busy 0. Inputs of 0/0 after reset therefore trigger no conversion.
- Scan: refresh counter 0..REFRESH_DIV−1; on wrap, digit index increments modulo 8 (7 → 0).
- Digit map: 0 hits ones; 1 hits tens; 2 hits hundreds; 3 blank; 4 level ones; 5 level tens; 6, 7 blank.
- Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens both 0; level tens blank if 0; digit 0 and digit 4 always lit.
- Blank digit: An all ones (1111_1111), Seg = 7'h7F. Lit digit i: An = ~(1<<i), Seg from decoder.
- Decoder (gfedcba, active-low): 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000; any other code 1111111.

## Timing
- Input stable before edge k with FSM in IDLE: load at edge k, shifts at edges k+1..k+8, display regs updated at edge k+9; Seg/An reflect new digits from edge k+10 onward for the active slot.
- Busy high from edge k to edge k+9 (exclusive of the IDLE cycle after).
- Back-to-back: input change during conversion → next conversion loads at edge k+10 earliest.
- Seg/An registered: one-cycle delay from digit index/display regs.
- Reset: An = 8'hFF, Seg = 7'h7F, refresh counter 0, digit index 0; first lit output on edge after Rst deasserts.
- Rst asserted mid-conversion: FSM returns to IDLE at that edge, partial result discarded, display regs forced to reset values.
- Digit index advances once per REFRESH_DIV cycles; full frame = 8·REFRESH_DIV cycles.

## Test plan
- Reset (REFRESH_DIV=4): Rst high 3 cycles → An=FF, Seg=7F, Busy=0; after release digit 0 shows Seg=1000000/An=FE, digit 4 Seg=1111001/An=EF, digits 1,2,3,5,6,7 An=FF.
- Hits=255, Level=15 applied before edge k → Busy high k..k+8, display regs 2/5/5 and 1/6 at edge k+9; scan shows digits 0–2 = 5,5,2 and digits 4–5 = 6,1.
- Hits=7, Level=8 → digit 0 shows 7 (1111000); digits 1,2 blank; digit 4 shows 9 (0010000); digit 5 blank.
- Hits changes 100→42 at edge k+3 of a conversion → display shows 100 at k+9, 42 at k+19; no intermediate value ever displayed.
- Rst at edge k+4 of a conversion of Hits=200 → display reverts to 0/01, Busy=0 next cycle, no 200 shown; release with Hits=200 → 200 displayed 9 cycles after first IDLE edge.
- Scan wrap: observe 8 slots of 4 cycles; digit index 7 → 0 with An cycling only over lit digits, frame period 32 cycles.
